// File: rtl/maze_pkg.sv
// Shared constants and types for the maze router SRAM responder.
// Holds map geometry, cell codes and the dump FSM state encoding.
package maze_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 8;
  localparam int GRID_WORDS = 64;

  localparam logic [DATA_WIDTH-1:0] EMPTY_VAL = 8'hFF;
  localparam logic [ADDR_WIDTH-1:0] TERM_BASE = 8'h80;
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR  = ADDR_WIDTH'(GRID_WORDS - 1);

  localparam logic [DATA_WIDTH-1:0] CELL_BLOCKED = 8'hFF;
  localparam logic [DATA_WIDTH-1:0] CELL_TERM    = 8'hEE;
  localparam logic [DATA_WIDTH-1:0] CELL_PATH    = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'b001,
    ST_DUMP_RD  = 3'b010,
    ST_DUMP_OUT = 3'b100
  } dump_state_e;

  // Selects which registered read output a core read lands in.
  typedef enum logic {
    DST_ROUTER = 1'b0,
    DST_DUMP   = 1'b1
  } rd_dst_e;

  function automatic logic [DATA_WIDTH-1:0] mask_empty(input logic                  valid,
                                                       input logic [DATA_WIDTH-1:0] data);
    return valid ? data : EMPTY_VAL;
  endfunction

endpackage

// File: rtl/maze_sram_core.sv
// Single-port map storage with per-word valid bits and registered read data.
// Each read lands in either the router or the dump output register.
module maze_sram_core
  import maze_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en_i,
  input  logic                  we_i,
  input  rd_dst_e               dst_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] router_rdata_o,
  output logic [DATA_WIDTH-1:0] dump_rdata_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]      vld_q;
  logic [DATA_WIDTH-1:0] router_rdata_q;
  logic [DATA_WIDTH-1:0] dump_rdata_q;
  logic [DATA_WIDTH-1:0] rd_word;

  // The array itself is never reset; vld_q alone decides whether a word reads as empty.
  always_ff @(posedge clk) begin
    if (en_i && we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
    end else if (en_i && we_i) begin
      vld_q[addr_i] <= 1'b1;
    end
  end

  assign rd_word = mask_empty(vld_q[addr_i], mem_q[addr_i]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      router_rdata_q <= EMPTY_VAL;
      dump_rdata_q   <= '0;
    end else if (en_i && !we_i) begin
      if (dst_i == DST_DUMP) begin
        dump_rdata_q <= rd_word;
      end else begin
        router_rdata_q <= rd_word;
      end
    end
  end

  assign router_rdata_o = router_rdata_q;
  assign dump_rdata_o   = dump_rdata_q;

endmodule

// File: rtl/maze_sram_responder.sv
// Router-facing SRAM responder: router port, host loader, grid dump FSM
// and a saturating router write counter around one single-port core.
module maze_sram_responder
  import maze_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cs,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  dump_start,
  output logic                  dump_valid,
  input  logic                  dump_ready,
  output logic [ADDR_WIDTH-1:0] dump_addr,
  output logic [DATA_WIDTH-1:0] dump_data,
  output logic                  dump_busy,
  output logic [15:0]           wr_count
);

  dump_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] dump_addr_q, dump_addr_d;
  logic                  dump_valid_q, dump_valid_d;
  logic                  dump_busy_q, dump_busy_d;
  logic [15:0]           wr_count_q;

  logic                  mem_en;
  logic                  mem_we;
  rd_dst_e               mem_dst;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  ld_fire;

  // Gated by reset_n so the loader sees ready low while reset is held.
  assign ld_ready = reset_n && !cs && (state_q == ST_IDLE);
  assign ld_fire  = ld_valid && ld_ready;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_dst   = DST_ROUTER;
    mem_addr  = address;
    mem_wdata = wr_data;
    if (cs) begin
      mem_en = 1'b1;
      mem_we = we;
    end else if (state_q == ST_DUMP_RD) begin
      mem_en   = 1'b1;
      mem_dst  = DST_DUMP;
      mem_addr = ptr_q;
    end else if (ld_fire) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = ld_addr;
      mem_wdata = ld_data;
    end
  end

  maze_sram_core u_core (
    .clk            (clk),
    .reset_n        (reset_n),
    .en_i           (mem_en),
    .we_i           (mem_we),
    .dst_i          (mem_dst),
    .addr_i         (mem_addr),
    .wdata_i        (mem_wdata),
    .router_rdata_o (rd_data),
    .dump_rdata_o   (dump_data)
  );

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    dump_addr_d  = dump_addr_q;
    dump_valid_d = dump_valid_q;
    dump_busy_d  = dump_busy_q;
    unique case (state_q)
      ST_IDLE: begin
        if (dump_start) begin
          state_d     = ST_DUMP_RD;
          ptr_d       = '0;
          dump_busy_d = 1'b1;
        end
      end
      ST_DUMP_RD: begin
        if (!cs) begin
          dump_addr_d  = ptr_q;
          dump_valid_d = 1'b1;
          state_d      = ST_DUMP_OUT;
        end
      end
      ST_DUMP_OUT: begin
        if (dump_ready) begin
          dump_valid_d = 1'b0;
          if (ptr_q == LAST_PTR) begin
            dump_busy_d = 1'b0;
            state_d     = ST_IDLE;
          end else begin
            ptr_d   = ptr_q + ADDR_WIDTH'(1);
            state_d = ST_DUMP_RD;
          end
        end
      end
      default: begin
        state_d      = ST_IDLE;
        dump_valid_d = 1'b0;
        dump_busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      dump_addr_q  <= '0;
      dump_valid_q <= 1'b0;
      dump_busy_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      dump_addr_q  <= dump_addr_d;
      dump_valid_q <= dump_valid_d;
      dump_busy_q  <= dump_busy_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_count_q <= '0;
    end else if (cs && we && (wr_count_q != 16'hFFFF)) begin
      wr_count_q <= wr_count_q + 16'd1;
    end
  end

  assign dump_valid = dump_valid_q;
  assign dump_addr  = dump_addr_q;
  assign dump_busy  = dump_busy_q;
  assign wr_count   = wr_count_q;

endmodule

// File: tb/tb_maze_sram_responder.sv
// Scoreboard bench for maze_sram_responder: stimulus pushes expected reads and dump
// words from a behavioural memory model; a negedge monitor pops and compares them.
module tb_maze_sram_responder;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } dump_exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cs = 1'b0;
  logic        we = 1'b0;
  logic [7:0]  address = '0;
  logic [7:0]  wr_data = '0;
  logic [7:0]  rd_data;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [7:0]  ld_addr = '0;
  logic [7:0]  ld_data = '0;
  logic        dump_start = 1'b0;
  logic        dump_valid;
  logic        dump_ready = 1'b0;
  logic [7:0]  dump_addr;
  logic [7:0]  dump_data;
  logic        dump_busy;
  logic [15:0] wr_count;

  int checks = 0;
  int errors = 0;

  logic [7:0]  refMem [256];
  bit          refVld [256];
  logic [15:0] refCount = '0;
  bit          dumpActive = 1'b0;
  logic [7:0]  rdQ [$];
  dump_exp_t   dumpQ [$];
  int          dumpSeen = 0;
  bit          busyCheck = 1'b0;
  logic        readFire;

  maze_sram_responder dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cs         (cs),
    .we         (we),
    .address    (address),
    .wr_data    (wr_data),
    .rd_data    (rd_data),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .dump_start (dump_start),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_addr  (dump_addr),
    .dump_data  (dump_data),
    .dump_busy  (dump_busy),
    .wr_count   (wr_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
    end
  endtask

  function automatic logic [7:0] refRead(input logic [7:0] a);
    return refVld[a] ? refMem[a] : 8'hFF;
  endfunction

  // One bus cycle: drive router and loader, update the model, queue the expected read.
  task automatic applyStimulus(input logic c, input logic w, input logic [7:0] a, input logic [7:0] d,
                               input logic lv = 1'b0, input logic [7:0] la = 8'h00,
                               input logic [7:0] ldd = 8'h00);
    cs = c; we = w; address = a; wr_data = d;
    ld_valid = lv; ld_addr = la; ld_data = ldd;
    if (c && w) begin
      refMem[a] = d;
      refVld[a] = 1'b1;
      if (refCount != 16'hFFFF) refCount = refCount + 16'd1;
    end else if (c) begin
      rdQ.push_back(refRead(a));
    end
    if (lv && !c && !dumpActive) begin
      refMem[la] = ldd;
      refVld[la] = 1'b1;
    end
    #1;
    if (lv) checkOutput("ld_ready", {31'd0, ld_ready}, {31'd0, !c});
    @(posedge clk);
    #1;
  endtask

  task automatic runDump(input int words);
    int        startSeen;
    logic      doRead;
    dump_exp_t e;
    for (int i = 0; i < 64; i++) begin
      e.addr = 8'(i);
      e.data = refRead(8'(i));
      dumpQ.push_back(e);
    end
    dumpActive = 1'b1;
    dump_start = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
    dump_start = 1'b0;
    startSeen = dumpSeen;
    for (int cyc = 0; cyc < 2000 && (dumpSeen - startSeen) < words; cyc++) begin
      dump_ready = ~dump_ready;
      doRead = ($urandom_range(0, 3) == 0);
      applyStimulus(doRead, 1'b0, 8'($urandom_range(0, 255)), 8'h00);
    end
    dump_ready = 1'b0;
    checkOutput("dump_word_count", dumpSeen - startSeen, words);
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) readFire <= 1'b0;
    else          readFire <= cs && !we;
  end

  always @(negedge clk) begin
    logic [7:0] expRd;
    dump_exp_t  de;
    if (reset_n) begin
      if (busyCheck) begin
        checkOutput("dump_busy_fall", {31'd0, dump_busy}, 32'd0);
        checkOutput("dump_valid_fall", {31'd0, dump_valid}, 32'd0);
        busyCheck = 1'b0;
      end
      if (readFire) begin
        if (rdQ.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL rd_data_unexpected actual=%0h required=no read pending", rd_data);
        end else begin
          expRd = rdQ.pop_front();
          checkOutput("rd_data", {24'd0, rd_data}, {24'd0, expRd});
        end
      end
      if (dump_valid && dump_ready) begin
        if (dumpQ.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL dump_unexpected actual=%0h required=no dump word pending", dump_addr);
        end else begin
          de = dumpQ.pop_front();
          checkOutput("dump_addr", {24'd0, dump_addr}, {24'd0, de.addr});
          checkOutput("dump_data", {24'd0, dump_data}, {24'd0, de.data});
          if (de.addr == 8'd63) begin
            checkOutput("dump_busy_last", {31'd0, dump_busy}, 32'd1);
            busyCheck = 1'b1;
          end
          dumpSeen++;
        end
      end
    end
  end

  initial begin
    int         r;
    int         sel;
    logic [7:0] a;
    logic [7:0] d;
    for (int i = 0; i < 256; i++) begin
      refMem[i] = 8'h00;
      refVld[i] = 1'b0;
    end

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_rd_data", {24'd0, rd_data}, 32'hFF);
    checkOutput("reset_ld_ready", {31'd0, ld_ready}, 32'd0);
    checkOutput("reset_dump_valid", {31'd0, dump_valid}, 32'd0);
    checkOutput("reset_dump_addr", {24'd0, dump_addr}, 32'd0);
    checkOutput("reset_dump_data", {24'd0, dump_data}, 32'd0);
    checkOutput("reset_dump_busy", {31'd0, dump_busy}, 32'd0);
    checkOutput("reset_wr_count", {16'd0, wr_count}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] reads of unwritten words");
    applyStimulus(1'b1, 1'b0, 8'h05, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'h80, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);

    $display("[TB] loader fill and back-to-back readback");
    for (int i = 0; i < 64; i++) applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'(i), 8'hEE);
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h80, 8'h09);
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h81, 8'h2A);
    for (int i = 0; i < 64; i++) applyStimulus(1'b1, 1'b0, 8'(i), 8'h00);
    applyStimulus(1'b1, 1'b0, 8'h80, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'h81, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);

    $display("[TB] router write then read");
    applyStimulus(1'b1, 1'b1, 8'h12, 8'h00);
    checkOutput("wr_count_first", {16'd0, wr_count}, {16'd0, refCount});
    applyStimulus(1'b1, 1'b0, 8'h12, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);

    $display("[TB] loader blocked by router");
    repeat (3) applyStimulus(1'b1, 1'b0, 8'h20, 8'h00, 1'b1, 8'h90, 8'h5A);
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h90, 8'h5A);
    applyStimulus(1'b1, 1'b0, 8'h90, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);

    $display("[TB] top address");
    applyStimulus(1'b1, 1'b1, 8'hFF, 8'h3C);
    applyStimulus(1'b1, 1'b0, 8'hFF, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);

    $display("[TB] random router and loader traffic");
    for (int i = 0; i < 300; i++) begin
      r   = $urandom_range(0, 9);
      sel = $urandom_range(0, 3);
      a   = (sel == 0) ? 8'hFF : (sel == 1) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 63));
      d   = 8'($urandom_range(0, 255));
      case (r)
        0, 1, 2, 3: applyStimulus(1'b1, 1'b0, a, 8'h00);
        4, 5:       applyStimulus(1'b1, 1'b1, a, d);
        6:          applyStimulus(1'b0, 1'b1, a, d);
        7, 8:       applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, a, d);
        default:    applyStimulus(1'b1, 1'b0, a, 8'h00, 1'b1, 8'($urandom_range(0, 255)), d);
      endcase
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
    checkOutput("wr_count_random", {16'd0, wr_count}, {16'd0, refCount});

    $display("[TB] full grid dump");
    runDump(64);
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
    dumpActive = 1'b0;
    checkOutput("dump_busy_idle", {31'd0, dump_busy}, 32'd0);
    checkOutput("dump_queue_drained", dumpQ.size(), 32'd0);

    $display("[TB] reset during dump");
    runDump(10);
    cs = 1'b0; we = 1'b0; ld_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    rdQ.delete();
    dumpQ.delete();
    for (int i = 0; i < 256; i++) refVld[i] = 1'b0;
    refCount   = '0;
    busyCheck  = 1'b0;
    dumpActive = 1'b0;
    #1;
    checkOutput("abort_dump_valid", {31'd0, dump_valid}, 32'd0);
    checkOutput("abort_dump_busy", {31'd0, dump_busy}, 32'd0);
    checkOutput("abort_rd_data", {24'd0, rd_data}, 32'hFF);
    checkOutput("abort_wr_count", {16'd0, wr_count}, 32'd0);
    checkOutput("abort_ld_ready", {31'd0, ld_ready}, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 8'h00, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'h05, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'h3F, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'h80, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'hFF, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
    checkOutput("read_queue_drained", rdQ.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/maze_sram_responder.md
Name: maze_sram_responder

Overview:
- Memory-side responder for the maze router's SRAM bus (cs/we/address/data).
- Holds the 256x8 map/terminal image and answers router reads and writes with a one-cycle registered read latency.
- Host side: a valid/ready loader port fills the image before the router starts.
- Host side: a valid/ready dump port streams the grid region out after routing completes, for checking.

Parameters:
- DATA_WIDTH, 8, word width.
- ADDR_WIDTH, 8, address width; depth = 2**ADDR_WIDTH.
- GRID_WORDS, 64, number of words streamed by a dump (addresses 0..GRID_WORDS-1).
- EMPTY_VAL, 8'hFF, read value returned for any word not written since reset.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- cs  in  1  router chip select.
- we  in  1  router write enable; valid only with cs.
- address  in  ADDR_WIDTH  router address.
- wr_data  in  DATA_WIDTH  router write data (router data_out).
- rd_data  out  DATA_WIDTH  read data to router (router data_in).
- ld_valid  in  1  loader word valid.
- ld_ready  out  1  loader accepted this cycle.
- ld_addr  in  ADDR_WIDTH  loader address.
- ld_data  in  DATA_WIDTH  loader data.
- dump_start  in  1  pulse: begin streaming the grid.
- dump_valid  out  1  dump word valid.
- dump_ready  in  1  dump sink ready.
- dump_addr  out  ADDR_WIDTH  address of dump word.
- dump_data  out  DATA_WIDTH  dump word.
- dump_busy  out  1  dump in progress.
- wr_count  out  16  router writes since reset, saturating at 16'hFFFF.

Behaviour:
- Storage and reset:
  - Single-port array mem[2**ADDR_WIDTH] plus a per-word valid bit vld[].
  - Asynchronous reset clears all vld bits, wr_count, and the FSM (to IDLE); the array contents are not cleared.
  - Reset values of outputs: rd_data = EMPTY_VAL, ld_ready = 0, dump_valid = 0, dump_addr = 0, dump_data = 0, dump_busy = 0, wr_count = 0.
- Router read (cs=1, we=0 at a rising edge):
  - rd_data <= vld[address] ? mem[address] : EMPTY_VAL.
  - Visible in the following cycle (1-cycle latency).
  - rd_data holds its value while cs=0.
- Router write (cs=1, we=1):
  - mem[address] <= wr_data and vld[address] <= 1.
  - wr_count increments, saturating.
  - rd_data is unchanged.
  - A read of the same address in the next cycle returns the new data.
- Port priority:
  - Router has absolute priority every cycle.
  - ld_ready = !cs && state==IDLE (combinational).
  - A loader word is written when ld_valid && ld_ready; it sets vld but does not affect wr_count.
  - A loader write and a router access never occur in the same cycle.
- Dump FSM, states IDLE, DUMP_RD, DUMP_OUT:
  - IDLE: dump_start -> DUMP_RD with ptr = 0 and dump_busy = 1. dump_start is ignored outside IDLE.
  - DUMP_RD: if cs=0, read mem[ptr] (EMPTY_VAL substitution applies) into dump_data, set dump_addr = ptr, dump_valid <= 1, then -> DUMP_OUT. If cs=1, stall in DUMP_RD.
  - DUMP_OUT: hold dump_data, dump_addr and dump_valid stable until dump_ready.
    - On handshake at ptr == GRID_WORDS-1: dump_valid <= 0, dump_busy <= 0, -> IDLE.
    - On handshake otherwise: ptr++, dump_valid <= 0, -> DUMP_RD.
  - Throughput: at most one word every 2 cycles.
  - The loader is blocked throughout a dump.
  - Router writes during a dump are allowed; a word reflects memory at the moment of its DUMP_RD read.
- Boundaries:
  - ptr width is ADDR_WIDTH, with no wrap beyond GRID_WORDS-1.
  - Address 2**ADDR_WIDTH-1 is a legal read/write target.
  - we without cs is ignored.
  - Reset asserted mid-dump aborts immediately: dump_valid = 0, state = IDLE; no partial handshake completes.
  - After reset, every read returns EMPTY_VAL until the word is written.

Decomposition:
- Shared package maze_pkg:
  - DATA_WIDTH, ADDR_WIDTH, GRID_WORDS, EMPTY_VAL.
  - Terminal-list base address 8'h80.
  - Cell codes: blocked FF, terminal marker EE, path 00.
  - Dump FSM state encoding, one-hot, 3 bits.
- One sub-module: maze_sram_core.
  - Holds the array plus valid bits.
  - Single port: one read or write per cycle, registered read output, async vld clear.
- The top level holds the port mux, the dump FSM and wr_count.

Test Plan:
- Reset, then router read of 0x05 and 0x80 -> rd_data = 8'hFF on both, each one cycle after its cs edge.
- Load 0x00..0x3F with 8'hEE plus 0x80 = 8'h09, 0x81 = 8'h2A, then router reads 0x00..0x3F, 0x80, 0x81 back-to-back -> 64 words of EE, then 09, then 2A, with 1-cycle latency and no bubbles.
- Router write 0x12 = 00, then read 0x12 next cycle -> rd_data = 00; wr_count = 1.
- Loader holds ld_valid while router cs=1 for 3 cycles -> ld_ready = 0 for those cycles; the word is written on the first cs=0 cycle.
- dump_start after loading the map, with dump_ready toggling every other cycle -> 64 words with dump_addr 0..63 in order, data matching the map, dump_busy falls after the word at address 63.
- dump_start, then reset_n low after word 10 -> dump_valid and dump_busy = 0 asynchronously; subsequent reads return FF.
